// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW interlock and taken-jump flush controller for the 5-stage 8-bit pipeline
// ports: clock, reset_n (sync, active low); id_* describe the instruction sitting in ID;
// ex_jump_valid/ex_taken resolve a jump in EX; pc_en/if_id_en/if_id_kill/id_ex_bubble steer
// the pipeline registers; stall_cnt/flush_cnt are saturating perf counters; state is RUN/STALL/FLUSH.
module pipeline_hazard_ctrl #(
  parameter int RA_W = 2,
  parameter int CNT_W = 16,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs_a,
  input  logic             id_rs_used,
  input  logic [RA_W-1:0]  id_rd_a,
  input  logic             id_rd_used,
  input  logic             id_reg_w_en,
  input  logic             id_is_jump,
  input  logic             ex_jump_valid,
  input  logic             ex_taken,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_kill,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  state_t cur, nxt;
  logic ex_v, mem_v, wb_v;
  logic [RA_W-1:0] ex_a, mem_a, wb_a;
  logic rs_hit, rd_hit, hazard, flush, stall, issue;
  logic unused_jump;
  // reserved for static prediction; deliberately has no effect
  assign unused_jump = id_is_jump;
  assign state = cur;
  always_comb begin
    rs_hit = (ex_v && ex_a == id_rs_a) || (mem_v && mem_a == id_rs_a) ||
             (!WB_BYPASS && wb_v && wb_a == id_rs_a);
    rd_hit = (ex_v && ex_a == id_rd_a) || (mem_v && mem_a == id_rd_a) ||
             (!WB_BYPASS && wb_v && wb_a == id_rd_a);
    hazard = id_valid && ((id_rs_used && rs_hit) || (id_rd_used && rd_hit));
    // EX holds our own bubble during FLUSH, so a still-high jump there is stale
    flush = ex_jump_valid && ex_taken && cur != FLUSH;
    stall = hazard && !flush;
    issue = id_valid && !hazard && !flush;
    nxt = flush ? FLUSH : hazard ? STALL : RUN;
    pc_en = !stall;
    if_id_en = !stall;
    if_id_kill = flush;
    id_ex_bubble = flush || hazard;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ex_v <= 1'b0;
      mem_v <= 1'b0;
      wb_v <= 1'b0;
      ex_a <= '0;
      mem_a <= '0;
      wb_a <= '0;
      cur <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_v <= issue && id_reg_w_en;
      ex_a <= (issue && id_reg_w_en) ? id_rd_a : '0;
      mem_v <= ex_v;
      mem_a <= ex_a;
      wb_v <= mem_v;
      wb_a <= mem_a;
      cur <= nxt;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
